// File: rtl/kem_seq_ctrl.sv
// ML-KEM top-level step sequencer: issues unit start pulses in a fixed order,
// walks the SampleA/CBD/NTT index loops and aborts on a hung unit.
module kem_seq_ctrl #(
    parameter int K       = 2,
    parameter int TIMEOUT = 4096,
    parameter int IW      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [2:0]    mode_i,
    input  logic [4:0]    mod_done_i,
    input  logic          ntt_done_i,
    output logic [4:0]    mod_start_o,
    output logic          ntt_start_o,
    output logic [2:0]    ntt_mode_o,
    output logic [IW-1:0] row_o,
    output logic [IW-1:0] col_o,
    output logic [IW-1:0] poly_idx_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    // kem_module_t bit layout
    localparam int M_TRNG  = 0;
    localparam int M_SAMPA = 1;
    localparam int M_CBD   = 2;
    localparam int M_HASHG = 3;
    localparam int M_LOM   = 4;

    // kem_mode_t / ntt_mode_t encodings
    localparam logic [2:0] MODE_KEYGEN = 3'b001;
    localparam logic [2:0] MODE_ENCAP  = 3'b010;
    localparam logic [2:0] MODE_DECAP  = 3'b100;
    localparam logic [2:0] NTT_A       = 3'd1;
    localparam logic [2:0] NTT_B       = 3'd2;

    localparam int WW = $clog2(TIMEOUT);

    localparam logic [IW-1:0] K_LAST   = IW'(K - 1);
    localparam logic [IW-1:0] K2_LAST  = IW'(2 * K - 1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRNG,
        S_HASHG,
        S_SAMPA,
        S_CBD,
        S_NTT,
        S_LOM,
        S_FIN
    } state_t;

    state_t        state;
    logic          is_keygen;
    logic [WW-1:0] wdog;
    logic          hit;
    logic          mode_ok;
    logic [IW-1:0] ntt_last;

    assign mode_ok = (mode_i == MODE_KEYGEN) ||
                     (mode_i == MODE_ENCAP)  ||
                     (mode_i == MODE_DECAP);

    assign ntt_last = is_keygen ? K2_LAST : K_LAST;

    // Only the done of the unit currently being sequenced counts.
    always_comb begin
        hit = 1'b0;
        case (state)
            S_TRNG:  hit = mod_done_i[M_TRNG];
            S_HASHG: hit = mod_done_i[M_HASHG];
            S_SAMPA: hit = mod_done_i[M_SAMPA];
            S_CBD:   hit = mod_done_i[M_CBD];
            S_NTT:   hit = ntt_done_i;
            S_LOM:   hit = mod_done_i[M_LOM];
            default: hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            is_keygen   <= 1'b0;
            wdog        <= '0;
            mod_start_o <= '0;
            ntt_start_o <= 1'b0;
            ntt_mode_o  <= '0;
            row_o       <= '0;
            col_o       <= '0;
            poly_idx_o  <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            mod_start_o <= '0;
            ntt_start_o <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        if (mode_ok) begin
                            is_keygen <= (mode_i == MODE_KEYGEN);
                            busy_o    <= 1'b1;
                            wdog      <= '0;
                            if (mode_i == MODE_DECAP) begin
                                state                <= S_HASHG;
                                mod_start_o[M_HASHG] <= 1'b1;
                            end else begin
                                state               <= S_TRNG;
                                mod_start_o[M_TRNG] <= 1'b1;
                            end
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                S_FIN: state <= S_IDLE;
                default: begin
                    if (hit) begin
                        wdog <= '0;
                        case (state)
                            S_TRNG: begin
                                state                <= S_HASHG;
                                mod_start_o[M_HASHG] <= 1'b1;
                            end
                            S_HASHG: begin
                                state                <= S_SAMPA;
                                mod_start_o[M_SAMPA] <= 1'b1;
                            end
                            S_SAMPA: begin
                                if (col_o == K_LAST) begin
                                    col_o <= '0;
                                    if (row_o == K_LAST) begin
                                        row_o              <= '0;
                                        poly_idx_o         <= '0;
                                        state              <= S_CBD;
                                        mod_start_o[M_CBD] <= 1'b1;
                                    end else begin
                                        row_o                <= row_o + IW'(1);
                                        mod_start_o[M_SAMPA] <= 1'b1;
                                    end
                                end else begin
                                    col_o                <= col_o + IW'(1);
                                    mod_start_o[M_SAMPA] <= 1'b1;
                                end
                            end
                            S_CBD: begin
                                if (poly_idx_o == K2_LAST) begin
                                    poly_idx_o  <= '0;
                                    state       <= S_NTT;
                                    ntt_start_o <= 1'b1;
                                    ntt_mode_o  <= is_keygen ? NTT_A : NTT_B;
                                end else begin
                                    poly_idx_o         <= poly_idx_o + IW'(1);
                                    mod_start_o[M_CBD] <= 1'b1;
                                end
                            end
                            S_NTT: begin
                                if (poly_idx_o == ntt_last) begin
                                    poly_idx_o         <= '0;
                                    state              <= S_LOM;
                                    mod_start_o[M_LOM] <= 1'b1;
                                end else begin
                                    poly_idx_o  <= poly_idx_o + IW'(1);
                                    ntt_start_o <= 1'b1;
                                end
                            end
                            S_LOM: begin
                                state  <= S_FIN;
                                done_o <= 1'b1;
                                busy_o <= 1'b0;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end else if (wdog == WD_LAST) begin
                        // Hung unit: abandon the operation.
                        state      <= S_IDLE;
                        err_o      <= 1'b1;
                        busy_o     <= 1'b0;
                        row_o      <= '0;
                        col_o      <= '0;
                        poly_idx_o <= '0;
                        wdog       <= '0;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/kem_seq_ctrl.md
Name: kem_seq_ctrl

Overview:
- Top-level sequencer for the ML-KEM datapath.
- Accepts one operation request (keygen, encap or decap, kem_mode_t encoding).
- Issues one-cycle start pulses to the shared sub-modules, in a fixed order, using the kem_module_t bit layout: trng, sampleA, sampleCBD_2k, hashG, lom. It also drives the NTT unit.
- Waits for each unit's done before moving on. A watchdog aborts the operation if a unit hangs.

Parameters:
- K, 2: ML-KEM rank. Legal values are 2, 3 and 4.
- TIMEOUT, 4096: maximum cycles spent waiting for any single done. Must be at least 2.
- IW, 3: width of index outputs. Must satisfy 2^IW ≥ 2K.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- start_i  in  1  operation request; sampled only in IDLE.
- mode_i  in  3  kem_mode_t {keygen, encap, decap}; sampled together with start_i.
- mod_done_i  in  5  kem_module_t one-bit done per unit; each bit is a single-cycle pulse.
- ntt_done_i  in  1  NTT unit done pulse.
- mod_start_o  out  5  kem_module_t start pulses; at most one bit high in any cycle.
- ntt_start_o  out  1  NTT start pulse.
- ntt_mode_o  out  3  ntt_mode_t value, held stable while the NTT step runs.
- row_o  out  IW  sampleA row index i.
- col_o  out  IW  sampleA column index j.
- poly_idx_o  out  IW  polynomial index for CBD and NTT steps.
- busy_o  out  1  high from the cycle after an accepted start until done or error.
- done_o  out  1  one-cycle pulse on successful completion.
- err_o  out  1  one-cycle pulse on illegal mode or timeout.

Behaviour:
- Reset (asynchronous, any state): all outputs are 0 and the FSM returns to IDLE. A reset mid-operation abandons the operation; no done_o or err_o is produced for it.
- FSM states: IDLE, TRNG, HASHG, SAMPA, CBD, NTT, LOM, FIN.
- Every unit state except FIN has two phases:
  - ISSUE (1 cycle): the start pulse is asserted.
  - WAIT: the FSM waits for the matching done.
- Mode check in IDLE:
  - mode_i must be one-hot, otherwise err_o pulses the next cycle and the FSM stays in IDLE with busy_o = 0.
  - start_i while busy is ignored.
- Step sequence by mode:
  - keygen: TRNG, HASHG, SAMPA (K×K), CBD (2K), NTT with mode NTT_a (2K), LOM, FIN.
  - encap: TRNG, HASHG, SAMPA (K×K), CBD (2K), NTT with mode NTT_b (K), LOM, FIN.
  - decap: same as encap but TRNG is skipped.
- Timing:
  - An accepted start at cycle t gives busy_o = 1 and the first ISSUE pulse at t+1.
  - A done seen in cycle d gives the next ISSUE pulse in cycle d+1.
- Iteration order:
  - SAMPA is row-major: (0,0), (0,1), …, (K-1,K-1). row_o and col_o are valid from ISSUE through the done cycle.
  - CBD and NTT both use poly_idx_o = 0 … n-1, with the counter reset to 0 on entering each state.
- Done matching:
  - Only the done bit matching the current unit, and only during WAIT, advances the FSM.
  - Done in the ISSUE cycle is legal and counts as completion (zero-latency unit).
  - Any other done bit, or ntt_done_i outside the NTT step, is ignored.
- FIN: done_o = 1 and busy_o = 0 in the same cycle, then IDLE. A new start_i may be accepted in the cycle after FIN.
- Watchdog:
  - A counter is cleared on each ISSUE and increments during WAIT.
  - When it reaches TIMEOUT-1 without the matching done, err_o pulses, busy_o drops, all indices clear, and the FSM returns to IDLE.
  - If a done arrives in that same cycle, the done wins.
- Outside their active steps, row_o, col_o and poly_idx_o are 0 and ntt_mode_o holds its last value.

Test Plan:
- Keygen with K=2, every unit answering 3 cycles after start. Required response:
  - Start pulses in order: trng, hashG, four sampleA (0,0)(0,1)(1,0)(1,1), four CBD idx 0–3, four NTT_a idx 0–3, lom. That is 15 pulses in total.
  - Then a single done_o and busy_o = 0.
- Decap with K=2: no trng pulse; two NTT_b pulses (idx 0, 1); done_o after the lom done.
- mode_i = 3'b110 with start_i → err_o pulses once the next cycle, no start pulses, busy_o stays 0.
- Encap with the hashG done withheld and TIMEOUT=16 → err_o pulses exactly 16 cycles after the hashG ISSUE, then IDLE; a following legal start completes normally.
- Spurious sampleA done during the TRNG wait, plus a zero-latency done in the CBD ISSUE cycle → the spurious done is ignored; the zero-latency done advances the CBD index the next cycle.
- rst asserted during the CBD step of keygen → outputs are 0 immediately with no done/err; a second start after reset runs the full 15-pulse sequence.
